// File: rtl/lift_ctrl.sv
// -----------------------------------------------------------------------------
// lift_ctrl -- single-cabin lift controller with SCAN (elevator) scheduling.
//
// Requests from the cabin and hall buttons are OR-ed into a registered
// pending map. The cabin keeps travelling in its current direction while
// requests remain beyond it, stops and opens the door at any pending floor,
// and reverses only when nothing is left ahead.
//
// Optional feature: define LIFT_ESTOP_EN to add an emergency-stop input and
// a HALT state. The default build (macro undefined) has neither.
//
// Parameters
//   NUM_FLOORS  number of served floors (2..16)
//   FLOOR_W     width of the floor index (>= clog2(NUM_FLOORS))
//   MOVE_CYC    clock cycles to travel one floor (>= 1)
//   DOOR_CYC    clock cycles the door stays open (>= 1)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   estop_i      emergency stop (only with LIFT_ESTOP_EN)
//   cab_req_i    cabin floor buttons, bit f = floor f
//   hall_up_i    hall up-call buttons, bit f = floor f
//   hall_dn_i    hall down-call buttons, bit f = floor f
//   floor_o      current cabin floor
//   dir_o        00 stopped, 01 up, 10 down (11 never driven)
//   door_o       door open
//   busy_o       high in any state other than IDLE
//   pend_o       registered pending-request map
//   dbg_state_o  current FSM state encoding (debug observation)
// -----------------------------------------------------------------------------
module lift_ctrl #(
   parameter int NUM_FLOORS = 8,
   parameter int FLOOR_W    = 3,
   parameter int MOVE_CYC   = 4,
   parameter int DOOR_CYC   = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef LIFT_ESTOP_EN
   input  logic                  estop_i,
`endif
   input  logic [NUM_FLOORS-1:0] cab_req_i,
   input  logic [NUM_FLOORS-1:0] hall_up_i,
   input  logic [NUM_FLOORS-1:0] hall_dn_i,
   output logic [FLOOR_W-1:0]    floor_o,
   output logic [1:0]            dir_o,
   output logic                  door_o,
   output logic                  busy_o,
   output logic [NUM_FLOORS-1:0] pend_o,
   output logic [2:0]            dbg_state_o
);

   localparam int MCNT_W = (MOVE_CYC > 1) ? $clog2(MOVE_CYC) : 1;
   localparam int DCNT_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DN   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MOVE_UP   = 3'd1,
      ST_MOVE_DOWN = 3'd2,
`ifdef LIFT_ESTOP_EN
      ST_HALT      = 3'd4,
`endif
      ST_DOOR      = 3'd3
   } state_t;

   state_t                r_state;
   logic [FLOOR_W-1:0]    r_floor;
   logic [1:0]            r_dir;
   logic                  r_door;
   logic                  r_busy;
   logic [NUM_FLOORS-1:0] r_pend;
   logic [MCNT_W-1:0]     r_mcnt;
   logic [DCNT_W-1:0]     r_dcnt;
   logic                  r_last_up;   // last travel direction, up after reset

   function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i == int'(f));
      return m;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
      return m;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
      return m;
   endfunction

   logic [NUM_FLOORS-1:0] w_req_in;
   logic [NUM_FLOORS-1:0] w_floor_oh;
   logic [NUM_FLOORS-1:0] w_clr;
   logic [NUM_FLOORS-1:0] w_pend_nxt;
   logic [FLOOR_W-1:0]    w_next_floor;
   logic                  w_at_cur, w_above_cur, w_below_cur;
   logic                  w_at_nf, w_above_nf, w_below_nf;
   logic                  w_fwd, w_back;
   logic                  w_req_here;
   logic                  w_door_up, w_door_dn;
   logic                  w_mterm, w_dterm;

   assign w_req_in   = cab_req_i | hall_up_i | hall_dn_i;
   assign w_floor_oh = onehot(r_floor);
   // The floor being served is cleared every door cycle, so a button pressed
   // for that floor while the door is open never re-enters the map.
   assign w_clr      = (r_state == ST_DOOR) ? w_floor_oh : '0;
   assign w_pend_nxt = (r_pend | w_req_in) & ~w_clr;

   assign w_at_cur    = |(r_pend & w_floor_oh);
   assign w_above_cur = |(r_pend & above_mask(r_floor));
   assign w_below_cur = |(r_pend & below_mask(r_floor));

   // Floor the cabin reaches at the end of the current travel step; only
   // meaningful in the move states, where a request beyond exists.
   assign w_next_floor = (r_state == ST_MOVE_DOWN) ? (r_floor - 1'b1) : (r_floor + 1'b1);
   assign w_at_nf      = |(r_pend & onehot(w_next_floor));
   assign w_above_nf   = |(r_pend & above_mask(w_next_floor));
   assign w_below_nf   = |(r_pend & below_mask(w_next_floor));
   assign w_fwd        = (r_state == ST_MOVE_DOWN) ? w_below_nf : w_above_nf;
   assign w_back       = (r_state == ST_MOVE_DOWN) ? w_above_nf : w_below_nf;

   assign w_req_here = |(w_req_in & w_floor_oh);

   // Door-close decision keeps the previous travel direction when possible.
   assign w_door_up = r_last_up ? w_above_cur : (w_above_cur & ~w_below_cur);
   assign w_door_dn = r_last_up ? (w_below_cur & ~w_above_cur) : w_below_cur;

   assign w_mterm = (r_mcnt == MCNT_W'(MOVE_CYC - 1));
   assign w_dterm = (r_dcnt == DCNT_W'(DOOR_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_floor   <= '0;
         r_dir     <= DIR_STOP;
         r_door    <= 1'b0;
         r_busy    <= 1'b0;
         r_pend    <= '0;
         r_mcnt    <= '0;
         r_dcnt    <= '0;
         r_last_up <= 1'b1;
      end else begin
         r_pend <= w_pend_nxt;
`ifdef LIFT_ESTOP_EN
         if (estop_i) begin
            // Counters and floor hold; pending map keeps latching above.
            r_state <= ST_HALT;
            r_door  <= 1'b0;
            r_dir   <= DIR_STOP;
            r_busy  <= 1'b1;
         end else
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_at_cur) begin
                  r_state <= ST_DOOR;
                  r_door  <= 1'b1;
                  r_dir   <= DIR_STOP;
                  r_busy  <= 1'b1;
                  r_dcnt  <= '0;
               end else if (w_above_cur) begin
                  // Up is tested first so it wins a tie with requests below.
                  r_state   <= ST_MOVE_UP;
                  r_dir     <= DIR_UP;
                  r_busy    <= 1'b1;
                  r_mcnt    <= '0;
                  r_last_up <= 1'b1;
               end else if (w_below_cur) begin
                  r_state   <= ST_MOVE_DOWN;
                  r_dir     <= DIR_DN;
                  r_busy    <= 1'b1;
                  r_mcnt    <= '0;
                  r_last_up <= 1'b0;
               end else begin
                  r_busy <= 1'b0;
                  r_dir  <= DIR_STOP;
               end
            end

            ST_MOVE_UP, ST_MOVE_DOWN: begin
               if (!w_mterm) begin
                  r_mcnt <= r_mcnt + 1'b1;
               end else begin
                  r_mcnt  <= '0;
                  r_floor <= w_next_floor;
                  if (w_at_nf) begin
                     r_state <= ST_DOOR;
                     r_door  <= 1'b1;
                     r_dir   <= DIR_STOP;
                     r_dcnt  <= '0;
                  end else if (w_fwd) begin
                     r_state <= r_state;
                  end else if (w_back) begin
                     if (r_state == ST_MOVE_UP) begin
                        r_state   <= ST_MOVE_DOWN;
                        r_dir     <= DIR_DN;
                        r_last_up <= 1'b0;
                     end else begin
                        r_state   <= ST_MOVE_UP;
                        r_dir     <= DIR_UP;
                        r_last_up <= 1'b1;
                     end
                  end else begin
                     r_state <= ST_IDLE;
                     r_dir   <= DIR_STOP;
                     r_busy  <= 1'b0;
                  end
               end
            end

            ST_DOOR: begin
               if (w_req_here) begin
                  r_dcnt <= '0;
               end else if (!w_dterm) begin
                  r_dcnt <= r_dcnt + 1'b1;
               end else begin
                  r_dcnt <= '0;
                  r_door <= 1'b0;
                  if (w_door_up) begin
                     r_state   <= ST_MOVE_UP;
                     r_dir     <= DIR_UP;
                     r_mcnt    <= '0;
                     r_last_up <= 1'b1;
                  end else if (w_door_dn) begin
                     r_state   <= ST_MOVE_DOWN;
                     r_dir     <= DIR_DN;
                     r_mcnt    <= '0;
                     r_last_up <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_dir   <= DIR_STOP;
                     r_busy  <= 1'b0;
                  end
               end
            end

`ifdef LIFT_ESTOP_EN
            ST_HALT: begin
               r_state <= ST_IDLE;
               r_door  <= 1'b0;
               r_dir   <= DIR_STOP;
               r_busy  <= 1'b0;
            end
`endif

            default: begin
               r_state <= ST_IDLE;
               r_door  <= 1'b0;
               r_dir   <= DIR_STOP;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign floor_o     = r_floor;
   assign dir_o       = r_dir;
   assign door_o      = r_door;
   assign busy_o      = r_busy;
   assign pend_o      = r_pend;
   assign dbg_state_o = r_state;

endmodule

// File: doc/lift_ctrl.md
LIFT_CTRL -- requirements
Module: lift_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of served floors (2..16).
REQ-002 Parameter FLOOR_W, default 3, width of floor index (>= clog2(NUM_FLOORS)).
REQ-003 Parameter MOVE_CYC, default 4, clock cycles to travel one floor (>= 1).
REQ-004 Parameter DOOR_CYC, default 6, clock cycles door stays open (>= 1).
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 cab_req_i  input  NUM_FLOORS  cabin floor buttons, bit f = floor f.
REQ-008 hall_up_i  input  NUM_FLOORS  hall up-call buttons, bit f = floor f.
REQ-009 hall_dn_i  input  NUM_FLOORS  hall down-call buttons, bit f = floor f.
REQ-010 floor_o  output  FLOOR_W  current cabin floor.
REQ-011 dir_o  output  2  motion: 00 stopped, 01 up, 10 down; 11 never driven.
REQ-012 door_o  output  1  door open.
REQ-013 busy_o  output  1  high in any state other than IDLE.
REQ-014 pend_o  output  NUM_FLOORS  registered pending-request map.

Function
REQ-015 Pending map SHALL update each edge: pend <= (pend | cab_req_i | hall_up_i | hall_dn_i) & ~clr, clr = one-hot of floor_o while in DOOR.
REQ-016 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR; all outputs registered.
REQ-017 IDLE: pend[floor] -> DOOR; else any pend above -> MOVE_UP; else any below -> MOVE_DOWN; else stay.
REQ-018 MOVE_x: move counter counts 0..MOVE_CYC-1; on terminal count floor_o steps +/-1 and counter clears.
REQ-019 On arrival: pend at new floor -> DOOR; else requests further same direction -> keep moving; else opposite side -> reverse; else IDLE.
REQ-020 DOOR: door_o=1, dir_o=00, door counter counts DOOR_CYC cycles, then direction resolved as REQ-019 using last travel direction (up if none).
REQ-021 New request for floor_o during DOOR SHALL restart door counter and be cleared, not re-queued.
REQ-022 Request at floor_o in IDLE: door_o high after second rising edge following request assertion.
REQ-023 floor_o SHALL never exceed NUM_FLOORS-1 nor go below 0; direction forced to reverse/IDLE at ends.
REQ-024 Simultaneous requests above and below while idle: up SHALL win.
REQ-025 Requests arriving during motion SHALL be latched and served per SCAN order, no loss.

Reset
REQ-026 rst_n low asynchronously: state IDLE, floor_o 0, dir_o 00, door_o 0, busy_o 0, pend_o 0, counters 0.
REQ-027 Reset mid-motion or mid-door SHALL discard all pending requests and re-home to floor 0.

Configuration
REQ-028 Macro LIFT_ESTOP_EN SHALL, when defined, add input estop_i (1 bit) and state HALT.
REQ-029 With LIFT_ESTOP_EN: estop_i high -> HALT next edge from any state; door_o 0, dir_o 00, counters frozen, floor_o held, requests still latched; estop_i low -> IDLE.
REQ-030 Without LIFT_ESTOP_EN: no estop_i port, no HALT state, behaviour per REQ-015..025.

Verification (NUM_FLOORS=8, MOVE_CYC=4, DOOR_CYC=6)
REQ-031 Reset, cab_req_i=0x01 one cycle -> door_o high 2 edges later for 6 cycles, floor_o 0, pend_o back to 0.
REQ-032 At floor 0 idle, cab_req_i=0x20 -> dir_o 01, floor_o reaches 5 after 20 cycles, door opens, then IDLE.
REQ-033 At floor 3 idle, hall_up_i=0x80 and hall_dn_i=0x01 same cycle -> goes up to 7, doors, then down to 0.
REQ-034 While moving 2->6, cab_req_i=0x10 before reaching 4 -> stops at 4, doors, continues to 6.
REQ-035 rst_n low while moving at floor 4 -> all outputs reset values immediately, pend_o 0.
REQ-036 With LIFT_ESTOP_EN, estop_i high mid-travel for 10 cycles -> floor_o held, dir_o 00, resumes from IDLE to pending floor.
